// File: rtl/conv_tile_sched_pkg.sv
// conv_tile_sched_pkg: shared tile size and scheduler state encoding for the conv tile scheduler.
package conv_tile_sched_pkg;

    localparam int TILE_LEN = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/conv_tile_extent.sv
// conv_tile_extent: extent (minus 1) of the tile at index idx_i along one dimension of an ofm_i-wide map.
module conv_tile_extent #(
    parameter int TILE_LEN  = 16,
    parameter int FMS_WIDTH = 8,
    parameter int PC_WIDTH  = 4,
    parameter int TC_WIDTH  = 6
) (
    input  logic [PC_WIDTH-1:0]  idx_i,
    input  logic [FMS_WIDTH-1:0] ofm_i,
    output logic [TC_WIDTH-1:0]  tc_max_o
);

    logic [FMS_WIDTH-1:0] rem;

    always_comb begin
        rem      = ofm_i - FMS_WIDTH'(idx_i) * FMS_WIDTH'(TILE_LEN);
        tc_max_o = rem >= FMS_WIDTH'(TILE_LEN) ? TC_WIDTH'(TILE_LEN - 1) : TC_WIDTH'(rem - 1'b1);
    end

endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks a job's output map in raster tile order, launching conv2d_1x1 once per tile
// and pulsing job_done after the last tile completes.
module conv_tile_sched
    import conv_tile_sched_pkg::*;
#(
    parameter int CHN_WIDTH    = 4,
    parameter int FMS_WIDTH    = 8,
    parameter int TC_ROW_WIDTH = 6,
    parameter int TC_COL_WIDTH = 6,
    parameter int PC_ROW_WIDTH = 4,
    parameter int PC_COL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    job_start,
    input  logic [CHN_WIDTH-1:0]    job_ci,
    input  logic [CHN_WIDTH-1:0]    job_co,
    input  logic                    job_stride,
    input  logic [FMS_WIDTH-1:0]    job_ifm_size,
    input  logic                    conv_done,
    output logic [CHN_WIDTH-1:0]    cfg_ci,
    output logic [CHN_WIDTH-1:0]    cfg_co,
    output logic                    cfg_stride,
    output logic [FMS_WIDTH-1:0]    cfg_ifm_size,
    output logic                    start_conv,
    output logic [PC_ROW_WIDTH-1:0] tile_row_offset,
    output logic [PC_COL_WIDTH-1:0] tile_col_offset,
    output logic [TC_ROW_WIDTH-1:0] tc_row_max,
    output logic [TC_COL_WIDTH-1:0] tc_col_max,
    output logic                    job_busy,
    output logic                    job_done,
    output logic [7:0]              tiles_done
);

    localparam int NT_WIDTH = FMS_WIDTH - $clog2(TILE_LEN) + 1;

    sched_state_e            state_q, state_d;
    logic [CHN_WIDTH-1:0]    ci_q, co_q;
    logic                    stride_q;
    logic [FMS_WIDTH-1:0]    ifm_q, ofm_q;
    logic [NT_WIDTH-1:0]     ntile_q;
    logic [PC_ROW_WIDTH-1:0] row_q, row_d;
    logic [PC_COL_WIDTH-1:0] col_q, col_d;
    logic [TC_ROW_WIDTH-1:0] tc_row_q, tc_row_next;
    logic [TC_COL_WIDTH-1:0] tc_col_q, tc_col_next;
    logic                    start_q, busy_q, done_q;
    logic [7:0]              tiles_q;
    logic [FMS_WIDTH:0]      ofm_job, ntile_job;
    logic                    last_row, last_col;

    // Output size is derived straight from the job inputs so it is ready in LOAD.
    assign ofm_job   = job_stride ? ({1'b0, job_ifm_size} + 1'b1) >> 1 : {1'b0, job_ifm_size};
    assign ntile_job = (ofm_job + (FMS_WIDTH+1)'(TILE_LEN - 1)) >> $clog2(TILE_LEN);
    assign last_row  = NT_WIDTH'(row_q) == ntile_q - 1'b1;
    assign last_col  = NT_WIDTH'(col_q) == ntile_q - 1'b1;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                state_d = job_start ? LOAD : IDLE;
                row_d   = job_start ? '0 : row_q;
                col_d   = job_start ? '0 : col_q;
            end
            LOAD:    state_d = ofm_q != '0 ? ISSUE : DONE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = !conv_done ? WAIT : (last_row && last_col) ? DONE : NEXT;
            NEXT: begin
                state_d = ISSUE;
                col_d   = last_col ? '0 : col_q + 1'b1;
                row_d   = last_col ? row_q + 1'b1 : row_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Extents follow the next-state index so they are registered alongside start_conv.
    conv_tile_extent #(
        .TILE_LEN(TILE_LEN), .FMS_WIDTH(FMS_WIDTH), .PC_WIDTH(PC_ROW_WIDTH), .TC_WIDTH(TC_ROW_WIDTH)
    ) u_row_ext (
        .idx_i(row_d), .ofm_i(ofm_q), .tc_max_o(tc_row_next)
    );

    conv_tile_extent #(
        .TILE_LEN(TILE_LEN), .FMS_WIDTH(FMS_WIDTH), .PC_WIDTH(PC_COL_WIDTH), .TC_WIDTH(TC_COL_WIDTH)
    ) u_col_ext (
        .idx_i(col_d), .ofm_i(ofm_q), .tc_max_o(tc_col_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ci_q     <= '0;
            co_q     <= '0;
            stride_q <= 1'b0;
            ifm_q    <= '0;
            ofm_q    <= '0;
            ntile_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            tc_row_q <= '0;
            tc_col_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tiles_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            start_q <= state_d == ISSUE;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
            if (state_q == IDLE && job_start) begin
                ci_q     <= job_ci;
                co_q     <= job_co;
                stride_q <= job_stride;
                ifm_q    <= job_ifm_size;
                ofm_q    <= ofm_job[FMS_WIDTH-1:0];
                ntile_q  <= ntile_job[NT_WIDTH-1:0];
                tiles_q  <= '0;
            end
            if (state_q == WAIT && conv_done)
                tiles_q <= tiles_q + 1'b1;
            if (state_d == ISSUE) begin
                tc_row_q <= tc_row_next;
                tc_col_q <= tc_col_next;
            end
        end
    end

    assign cfg_ci          = ci_q;
    assign cfg_co          = co_q;
    assign cfg_stride      = stride_q;
    assign cfg_ifm_size    = ifm_q;
    assign start_conv      = start_q;
    assign tile_row_offset = row_q;
    assign tile_col_offset = col_q;
    assign tc_row_max      = tc_row_q;
    assign tc_col_max      = tc_col_q;
    assign job_busy        = busy_q;
    assign job_done        = done_q;
    assign tiles_done      = tiles_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: table-driven and randomized job checks of conv_tile_sched against a tile-list model.
module tb_conv_tile_sched;

    logic       clk = 1'b0, rstn = 1'b0;
    logic       job_start = 1'b0, job_stride = 1'b0, conv_done = 1'b0;
    logic [3:0] job_ci = '0, job_co = '0;
    logic [7:0] job_ifm_size = '0;
    logic [3:0] cfg_ci, cfg_co;
    logic       cfg_stride;
    logic [7:0] cfg_ifm_size;
    logic       start_conv;
    logic [3:0] tile_row_offset, tile_col_offset;
    logic [5:0] tc_row_max, tc_col_max;
    logic       job_busy, job_done;
    logic [7:0] tiles_done;

    int checks = 0, errors = 0;

    typedef struct { int r; int c; int tr; int tc; } tile_t;
    typedef struct { int ifm; int stride; bit stray; int tiles; int edge_tc; } vec_t;

    conv_tile_sched dut (
        .clk(clk), .rstn(rstn), .job_start(job_start), .job_ci(job_ci), .job_co(job_co),
        .job_stride(job_stride), .job_ifm_size(job_ifm_size), .conv_done(conv_done),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_stride(cfg_stride), .cfg_ifm_size(cfg_ifm_size),
        .start_conv(start_conv), .tile_row_offset(tile_row_offset), .tile_col_offset(tile_col_offset),
        .tc_row_max(tc_row_max), .tc_col_max(tc_col_max), .job_busy(job_busy), .job_done(job_done),
        .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ext(input int ofm, input int idx);
        int rem = ofm - idx * 16;
        return (rem >= 16 ? 16 : rem) - 1;
    endfunction

    // Drives one whole job cycle-exactly and checks every tile launch against the model list.
    task automatic run_job(input int ifm, input int stride, input bit stray, output int ntl, output int edge_tc);
        int ofm, n, ci, co;
        tile_t q[$];
        ofm = stride != 0 ? (ifm + 1) / 2 : ifm;
        n = (ofm + 15) / 16;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                q.push_back('{r, c, ext(ofm, r), ext(ofm, c)});
        ci = int'($urandom_range(0, 15));
        co = int'($urandom_range(0, 15));
        edge_tc = 0;
        @(negedge clk);
        job_start = 1'b1; job_ci = 4'(ci); job_co = 4'(co); job_ifm_size = 8'(ifm); job_stride = stride[0];
        @(negedge clk);
        job_start = 1'b0; job_ci = 4'($urandom); job_co = 4'($urandom);
        job_ifm_size = 8'($urandom); job_stride = 1'($urandom);
        check("load_busy", int'(job_busy), 1);
        check("load_start", int'(start_conv), 0);
        check("load_tiles", int'(tiles_done), 0);
        @(negedge clk);
        if (q.size() == 0) begin
            check("zero_done", int'(job_done), 1);
            check("zero_start", int'(start_conv), 0);
        end
        for (int k = 0; k < q.size(); k++) begin
            check("issue_start", int'(start_conv), 1);
            check("issue_row", int'(tile_row_offset), q[k].r);
            check("issue_col", int'(tile_col_offset), q[k].c);
            check("issue_tc_row", int'(tc_row_max), q[k].tr);
            check("issue_tc_col", int'(tc_col_max), q[k].tc);
            check("cfg_ci", int'(cfg_ci), ci);
            check("cfg_co", int'(cfg_co), co);
            check("cfg_stride", int'(cfg_stride), stride);
            check("cfg_ifm", int'(cfg_ifm_size), ifm);
            if (k == q.size() - 1) edge_tc = int'(tc_col_max);
            if (stray) begin
                conv_done = 1'b1;
                job_start = 1'b1;
            end
            @(negedge clk);
            conv_done = 1'b0; job_start = 1'b0;
            check("wait_start", int'(start_conv), 0);
            check("wait_tiles", int'(tiles_done), k);
            repeat ($urandom_range(0, 3)) begin
                if (stray) job_start = 1'($urandom);
                @(negedge clk);
                job_start = 1'b0;
                check("hold_start", int'(start_conv), 0);
                check("hold_row", int'(tile_row_offset), q[k].r);
                check("hold_col", int'(tile_col_offset), q[k].c);
                check("hold_ifm", int'(cfg_ifm_size), ifm);
            end
            conv_done = 1'b1;
            @(negedge clk);
            conv_done = 1'b0;
            check("ack_tiles", int'(tiles_done), k + 1);
            if (k == q.size() - 1) begin
                check("last_done", int'(job_done), 1);
            end else begin
                check("mid_done", int'(job_done), 0);
                check("next_gap", int'(start_conv), 0);
                @(negedge clk);
            end
        end
        ntl = int'(tiles_done);
        if (stray) job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("idle_busy", int'(job_busy), 0);
        check("idle_done", int'(job_done), 0);
        @(negedge clk);
        check("idle_busy2", int'(job_busy), 0);
        check("idle_start2", int'(start_conv), 0);
    endtask

    vec_t vecs[8];
    int   ntl, etc;

    initial begin
        vecs[0] = '{32, 0, 1'b0, 4, 15};
        vecs[1] = '{40, 0, 1'b1, 9, 7};
        vecs[2] = '{35, 1, 1'b1, 4, 1};
        vecs[3] = '{0, 0, 1'b1, 0, 0};
        vecs[4] = '{226, 0, 1'b0, 225, 1};
        vecs[5] = '{17, 0, 1'b0, 4, 0};
        vecs[6] = '{1, 1, 1'b1, 1, 0};
        vecs[7] = '{255, 1, 1'b0, 64, 15};
        repeat (2) @(negedge clk);
        check("rst_busy", int'(job_busy), 0);
        check("rst_outs", int'(|{cfg_ci, cfg_co, cfg_stride, cfg_ifm_size, start_conv, tile_row_offset,
                                 tile_col_offset, tc_row_max, tc_col_max, job_done, tiles_done}), 0);
        rstn = 1'b1;
        foreach (vecs[i]) begin
            run_job(vecs[i].ifm, vecs[i].stride, vecs[i].stray, ntl, etc);
            check("vec_tiles", ntl, vecs[i].tiles);
            if (vecs[i].tiles != 0) check("vec_edge_tc", etc, vecs[i].edge_tc);
        end
        // Reset in the middle of a tile wait, then the next job must restart at tile (0,0).
        @(negedge clk);
        job_start = 1'b1; job_ifm_size = 8'd40; job_stride = 1'b0; job_ci = 4'd5; job_co = 4'd9;
        @(negedge clk);
        job_start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", int'(job_busy), 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_busy", int'(job_busy), 0);
        check("mid_rst_outs", int'(|{cfg_ci, cfg_co, cfg_stride, cfg_ifm_size, start_conv, tile_row_offset,
                                     tile_col_offset, tc_row_max, tc_col_max, job_done, tiles_done}), 0);
        @(negedge clk);
        rstn = 1'b1;
        run_job(40, 0, 1'b0, ntl, etc);
        check("post_rst_tiles", ntl, 9);
        for (int i = 0; i < 15; i++) begin
            int ifm = int'($urandom_range(0, 200));
            int st  = int'($urandom_range(0, 1));
            int ofm = st != 0 ? (ifm + 1) / 2 : ifm;
            int n   = (ofm + 15) / 16;
            run_job(ifm, st, 1'($urandom), ntl, etc);
            check("rand_tiles", ntl, n * n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
